// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request picker for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN: when defined, a tie is resolved in favour of
// the port named by i_prio (round-robin); when undefined, port 0 always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_grant
);

`ifdef DMEM_ARB_RR_EN
    // Single requester wins outright; on a tie the preferred port wins.
    always_comb begin
        o_grant = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_grant = i_prio;
        end else if (i_req1) begin
            o_grant = PORT_DBG;
        end
    end
`else
    // The preference pointer has no meaning under fixed priority.
    logic w_unused_prio;
    assign w_unused_prio = i_prio;

    // Port 0 wins whenever it requests; port 1 only when alone.
    always_comb begin
        o_grant = PORT_CPU;
        if (!i_req0 && i_req1) begin
            o_grant = PORT_DBG;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the processor (port 0)
// and the loader/debug port (port 1). Each transaction runs IDLE -> ACCESS ->
// RESP, so one access completes every three clocks at most.
// Build option DMEM_ARB_RR_EN selects round-robin tie breaking (see
// dmem_arb_pick); otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              D_rd,
    output logic              D_wr,
    output logic [ADDR_W-1:0] D_addr,
    output logic [DATA_W-1:0] W_data,
    input  logic [DATA_W-1:0] R_data,
    output logic              busy
);

    arb_state_t        r_state;
    logic              r_busy;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_d_rd;
    logic              r_d_wr;
    logic [ADDR_W-1:0] r_d_addr;
    logic [DATA_W-1:0] r_w_data;
    logic              r_win;
    logic              r_prio;

    logic              w_grant;
    logic              w_any_req;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    dmem_arb_pick u_pick (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    assign w_any_req   = req0 | req1;
    assign w_sel_we    = (w_grant == PORT_DBG) ? we1    : we0;
    assign w_sel_addr  = (w_grant == PORT_DBG) ? addr1  : addr0;
    assign w_sel_wdata = (w_grant == PORT_DBG) ? wdata1 : wdata0;

    // Transaction FSM. The memory pins are loaded on the grant edge so they
    // are stable registered values for the whole ACCESS cycle; the address
    // and write-data registers double as the command latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_d_rd   <= 1'b0;
            r_d_wr   <= 1'b0;
            r_d_addr <= '0;
            r_w_data <= '0;
            r_win    <= PORT_CPU;
            r_prio   <= PORT_CPU;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_any_req) begin
                        r_win    <= w_grant;
                        r_d_addr <= w_sel_addr;
                        r_w_data <= w_sel_wdata;
                        r_d_rd   <= ~w_sel_we;
                        r_d_wr   <= w_sel_we;
                        // Next tie goes to the port that just lost out.
                        r_prio   <= ~w_grant;
                        r_busy   <= 1'b1;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_d_rd) begin
                        if (r_win == PORT_DBG) begin
                            r_rdata1 <= R_data;
                        end else begin
                            r_rdata0 <= R_data;
                        end
                    end
                    r_d_rd  <= 1'b0;
                    r_d_wr  <= 1'b0;
                    r_ack0  <= (r_win == PORT_CPU);
                    r_ack1  <= (r_win == PORT_DBG);
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_d_rd  <= 1'b0;
                    r_d_wr  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign D_rd   = r_d_rd;
    assign D_wr   = r_d_wr;
    assign D_addr = r_d_addr;
    assign W_data = r_w_data;
    assign busy   = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 16x4 data memory.
module tb_dmem_arbiter;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          D_rd, D_wr;
    logic [AW-1:0] D_addr;
    logic [DW-1:0] W_data;
    logic [DW-1:0] R_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .D_rd   (D_rd),
        .D_wr   (D_wr),
        .D_addr (D_addr),
        .W_data (W_data),
        .R_data (R_data),
        .busy   (busy)
    );

    // Memory model: contents reloaded to (addr ^ 5) while reset is high.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i) ^ 4'h5;
        end else if (D_wr) begin
            mem[D_addr] <= W_data;
        end
    end
    assign R_data = D_rd ? mem[D_addr] : '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Protocol checker, sampled on every falling edge outside reset.
    logic prev_ack0 = 1'b0, prev_ack1 = 1'b0, seen0 = 1'b0, seen1 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_ack0 = 1'b0; prev_ack1 = 1'b0; seen0 = 1'b0; seen1 = 1'b0;
        end else begin
            checks++;
            if ((D_rd && D_wr) || (ack0 && prev_ack0) || (ack1 && prev_ack1) ||
                (ack0 && ack1) || (ack0 && !(seen0 || req0)) || (ack1 && !(seen1 || req1))) begin
                errors++;
                $display("FAIL protocol @%0t: D_rd=%b D_wr=%b ack0=%b ack1=%b prev=%b%b seen=%b%b, required no overlap/one-cycle ack/ack to requester",
                         $time, D_rd, D_wr, ack0, ack1, prev_ack0, prev_ack1, seen0, seen1);
            end
            if (req0) seen0 = 1'b1;
            if (req1) seen1 = 1'b1;
            if (ack0) seen0 = 1'b0;
            if (ack1) seen1 = 1'b0;
            prev_ack0 = ack0;
            prev_ack1 = ack1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        int  lat, t0, t1;
        logic got, other, win;
        logic exp_win [4];

        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Expected values: mem[i] = i ^ 5 after reset.
        vecs[0] = '{1'b0, 1'b1, 4'd8,  4'hF, 4'h0};
        vecs[1] = '{1'b0, 1'b0, 4'd8,  4'h0, 4'hF};
        vecs[2] = '{1'b1, 1'b0, 4'd3,  4'h0, 4'h6};
        vecs[3] = '{1'b1, 1'b1, 4'd0,  4'h7, 4'h6};
        vecs[4] = '{1'b1, 1'b0, 4'd0,  4'h0, 4'h7};
        vecs[5] = '{1'b0, 1'b0, 4'd15, 4'h0, 4'hA};
        vecs[6] = '{1'b0, 1'b1, 4'd15, 4'h0, 4'hA};
        vecs[7] = '{1'b1, 1'b0, 4'd15, 4'h0, 4'h0};

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({ack0, ack1, D_rd, D_wr, busy}), 32'd0);
        check("rst_addr", 32'(D_addr), 32'd0);
        check("rst_wdata", 32'(W_data), 32'd0);
        check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        reset = 1'b0;

        // Reset asserted in the middle of an ACCESS write to address 8
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 4'd8; wdata0 = 4'hC;
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_wr", 32'(D_wr), 32'd1);
        check("midrst_pre_addr", 32'(D_addr), 32'd8);
        #1 reset = 1'b1;
        #1;
        check("midrst_wr", 32'(D_wr), 32'd0);
        check("midrst_ctrl", 32'({ack0, ack1, D_rd, busy}), 32'd0);
        check("midrst_addr", 32'(D_addr), 32'd0);
        check("midrst_wdata", 32'(W_data), 32'd0);
        check("midrst_rdata", 32'({rdata0, rdata1}), 32'd0);
        req0 = 0; we0 = 0;
        @(negedge clk); reset = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) got = 1;
        end
        check("midrst_no_ack", 32'(got), 32'd0);

        // Single-requester table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (vecs[i].port) begin
                req1 = 1; we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
            end else begin
                req0 = 1; we0 = vecs[i].we; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
            end
            lat = 0; got = 0; other = 0;
            while (!got && lat < 10) begin
                @(negedge clk); lat++;
                if (lat == 2) begin
                    check($sformatf("v%0d_rd", i), 32'(D_rd), 32'(!vecs[i].we));
                    check($sformatf("v%0d_wr", i), 32'(D_wr), 32'(vecs[i].we));
                    check($sformatf("v%0d_addr", i), 32'(D_addr), 32'(vecs[i].addr));
                    check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
                    if (vecs[i].we) check($sformatf("v%0d_wdata", i), 32'(W_data), 32'(vecs[i].wdata));
                end else if (lat == 1) begin
                    check($sformatf("v%0d_idle_rdwr", i), 32'({D_rd, D_wr}), 32'd0);
                end
                if (vecs[i].port ? ack1 : ack0) got = 1;
                if (vecs[i].port ? ack0 : ack1) other = 1;
            end
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_rdata", i), 32'(vecs[i].port ? rdata1 : rdata0), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_other_ack", i), 32'(other), 32'd0);
            req0 = 0; req1 = 0;
            @(negedge clk);
            check($sformatf("v%0d_after", i), 32'({ack0, ack1, busy, D_rd, D_wr}), 32'd0);
        end

        // Both ports requesting continuously: four transactions
`ifdef DMEM_ARB_RR_EN
        exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 4'd1;
        req1 = 1; we1 = 0; addr1 = 4'd2;
        for (int k = 0; k < 4; k++) begin
            lat = 0; got = 0; win = 0;
            while (!got && lat < 10) begin
                @(negedge clk); lat++;
                if (ack0 || ack1) begin got = 1; win = ack1; end
            end
            check($sformatf("tie%0d_lat", k), 32'(lat), 32'd3);
            check($sformatf("tie%0d_grant", k), 32'(win), 32'(exp_win[k]));
            check($sformatf("tie%0d_rdata", k), 32'(win ? rdata1 : rdata0), win ? 32'h7 : 32'h4);
        end
        req0 = 0; req1 = 0;

        // Port 1 writes addr 5 while port 0 waits to read it
        @(posedge clk); @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 4'd5; wdata1 = 4'hA;
        @(negedge clk);
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 4'd5;
        lat = 1; t0 = 0; t1 = 0;
        while (t0 == 0 && lat < 14) begin
            @(negedge clk); lat++;
            if (ack1) begin t1 = lat; req1 = 0; end
            if (ack0) begin t0 = lat; req0 = 0; end
        end
        req0 = 0; req1 = 0;
        check("raw_ack1_cycle", 32'(t1), 32'd3);
        check("raw_ack0_cycle", 32'(t0), 32'd6);
        check("raw_rdata0", 32'(rdata0), 32'hA);

        // Port 0 drops its request once the command is latched
        @(posedge clk); @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 4'd4;
        @(negedge clk);
        @(posedge clk); #1;
        req0 = 0;
        lat = 1; got = 0;
        while (!got && lat < 10) begin
            @(negedge clk); lat++;
            if (ack0) got = 1;
        end
        check("drop_lat", 32'(lat), 32'd3);
        check("drop_rdata0", 32'(rdata0), 32'h1);
        @(negedge clk);
        check("drop_idle", 32'({ack0, busy}), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
